// File: rtl/act_unit_pipe_if.sv
// Activation-stage stream interface: input beat, output beat and zero-count statistic.
interface act_unit_pipe_if #(
    parameter int DATA_W = 10,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [1:0]                in_mode;
    logic [DATA_W-2:0]         clip_max;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      clr_cnt;
    logic [CNT_W-1:0]          zero_cnt;

    // Producer/consumer side (upstream requantiser + downstream buffer)
    modport master (
        output in_valid, in_data, in_mode, clip_max, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, zero_cnt
    );

    // Activation unit side
    modport slave (
        input  in_valid, in_data, in_mode, clip_max, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, zero_cnt
    );
endinterface

// File: rtl/act_unit_pipe.sv
// Two-stage pipelined activation unit: bypass / ReLU / leaky ReLU / clipped ReLU
// per beat, with a saturating count of negative inputs forced to zero.

// Single-lane activation function, purely combinational.
module act_unit_lane #(
    parameter int DATA_W     = 10,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic        [1:0]        mode,
    input  logic        [DATA_W-2:0] clip_max,
    output logic signed [DATA_W-1:0] y,
    output logic                     zeroed
);
    logic                     neg;
    logic signed [DATA_W-1:0] leak;
    logic signed [DATA_W-1:0] clipped;

    // Select the activation result; clip compares only the magnitude bits since x>=0 there
    always_comb begin
        neg     = x[DATA_W-1];
        leak    = x >>> LEAK_SHIFT;
        clipped = (x[DATA_W-2:0] > clip_max) ? {1'b0, clip_max} : x;
        y       = x;
        unique case (mode)
            2'd0:    y = x;
            2'd1:    y = neg ? '0 : x;
            2'd2:    y = neg ? leak : x;
            default: y = neg ? '0 : clipped;
        endcase
        // Modes 1 and 3 (bit0 set) are the ones that zero negative inputs
        zeroed = neg & mode[0];
    end
endmodule

module act_unit_pipe #(
    parameter int DATA_W     = 10,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    act_unit_pipe_if.slave io
);
    localparam int ZW = $clog2(LANES + 1);

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
    logic [2:1]        vld_pipe;
    logic              adv1, adv2, in_hs, out_hs;

    vec_t              s1_data;
    logic [1:0]        s1_mode;
    logic [DATA_W-2:0] s1_clip;
    vec_t              s1_res;
    logic [LANES-1:0]  lane_zero;
    logic [ZW-1:0]     s1_nz;

    vec_t              s2_data;
    logic [ZW-1:0]     s2_nz;

    logic [CNT_W-1:0]  zero_cnt_q;
    logic [CNT_W:0]    cnt_sum;

    assign adv2   = ~vld_pipe[2] | io.out_ready;
    assign adv1   = ~vld_pipe[1] | adv2;
    assign in_hs  = io.in_valid & adv1;
    assign out_hs = vld_pipe[2] & io.out_ready;

    assign io.in_ready  = adv1;
    assign io.out_valid = vld_pipe[2];
    assign io.out_data  = s2_data;
    assign io.zero_cnt  = zero_cnt_q;

    // Stage valid bits: S1 fills on handshake or drains when it moves on; S2 follows S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (in_hs)
                vld_pipe[1] <= 1'b1;
            else if (adv1)
                vld_pipe[1] <= 1'b0;
            if (adv2)
                vld_pipe[2] <= vld_pipe[1];
        end
    end

    // S1 capture: data, mode and clip ceiling travel together with the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0;
            s1_mode <= '0;
            s1_clip <= '0;
        end else if (in_hs) begin
            s1_data <= vec_t'(io.in_data);
            s1_mode <= io.in_mode;
            s1_clip <= io.clip_max;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            act_unit_lane #(
                .DATA_W     (DATA_W),
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_lane (
                .x        (s1_data[g]),
                .mode     (s1_mode),
                .clip_max (s1_clip),
                .y        (s1_res[g]),
                .zeroed   (lane_zero[g])
            );
        end
    endgenerate

    // Number of lanes in the S1 beat that the activation zeroed because x<0
    always_comb begin
        s1_nz = '0;
        for (int i = 0; i < LANES; i++)
            s1_nz = s1_nz + ZW'(lane_zero[i]);
    end

    // S2 result register; holds while stalled so out_data stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data <= '0;
            s2_nz   <= '0;
        end else if (adv2) begin
            s2_data <= s1_res;
            s2_nz   <= s1_nz;
        end
    end

    // One extra bit catches the carry that signals saturation
    always_comb begin
        cnt_sum = {1'b0, zero_cnt_q} + (CNT_W+1)'(s2_nz);
    end

    // Saturating zero counter, credited when the beat leaves; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_cnt_q <= '0;
        else if (io.clr_cnt)
            zero_cnt_q <= '0;
        else if (out_hs)
            zero_cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed bench for act_unit_pipe: single beats per mode, stalled stream,
// counter saturation/clear on a CNT_W=4 instance, and async reset mid-stream.
module tb_act_unit_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    act_unit_pipe_if #(.DATA_W(10), .LANES(4), .CNT_W(16)) u_if ();
    act_unit_pipe_if #(.DATA_W(10), .LANES(4), .CNT_W(4))  u_if4 ();

    act_unit_pipe #(.DATA_W(10), .LANES(4), .LEAK_SHIFT(3), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (u_if.slave)
    );

    act_unit_pipe #(.DATA_W(10), .LANES(4), .LEAK_SHIFT(3), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (u_if4.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lane 0 is the first argument
    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
        logic [9:0] la, lb, lc, ld;
        la = 10'(a); lb = 10'(b); lc = 10'(c); ld = 10'(d);
        return {ld, lc, lb, la};
    endfunction

    // One isolated beat on the main DUT with out_ready=1: checks 2-cycle latency and result
    task automatic run_beat(input string tag, input logic [1:0] mode, input logic [8:0] clip,
                            input logic [39:0] din, input logic [39:0] exp);
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.in_mode  = mode;
        u_if.clip_max = clip;
        u_if.in_data  = din;
        #1 chk({tag, "_in_ready"}, u_if.in_ready, 1);
        @(posedge clk);
        #1 u_if.in_valid = 1'b0;
        chk({tag, "_lat1"}, u_if.out_valid, 0);
        @(posedge clk);
        #1 chk({tag, "_lat2"}, u_if.out_valid, 1);
        chk({tag, "_data"}, u_if.out_data, exp);
        @(posedge clk);
        #1 chk({tag, "_drain"}, u_if.out_valid, 0);
    endtask

    // One all-negative mode-1 beat on the CNT_W=4 instance; clr optionally with its output handshake
    task automatic sat_beat(input logic clr);
        @(negedge clk);
        u_if4.in_valid = 1'b1;
        u_if4.in_mode  = 2'd1;
        u_if4.in_data  = pk(-1, -2, -3, -4);
        @(posedge clk);
        #1 u_if4.in_valid = 1'b0;
        @(posedge clk);
        #1 u_if4.clr_cnt = clr;
        @(posedge clk);
        #1 u_if4.clr_cnt = 1'b0;
    endtask

    logic [39:0] s_in  [8];
    logic [39:0] s_exp [8];
    logic [1:0]  s_mode[8];
    logic [8:0]  s_clip[8];

    initial begin
        s_in[0] = pk(1, -2, 3, -4);        s_mode[0] = 2'd0; s_clip[0] = 9'd0;   s_exp[0] = pk(1, -2, 3, -4);
        s_in[1] = pk(-10, 20, -30, 40);    s_mode[1] = 2'd1; s_clip[1] = 9'd0;   s_exp[1] = pk(0, 20, 0, 40);
        s_in[2] = pk(-16, 16, -1, -9);     s_mode[2] = 2'd2; s_clip[2] = 9'd0;   s_exp[2] = pk(-2, 16, -1, -2);
        s_in[3] = pk(60, 50, -7, 49);      s_mode[3] = 2'd3; s_clip[3] = 9'd50;  s_exp[3] = pk(50, 50, 0, 49);
        s_in[4] = pk(511, -512, 0, 5);     s_mode[4] = 2'd0; s_clip[4] = 9'd0;   s_exp[4] = pk(511, -512, 0, 5);
        s_in[5] = pk(-1, -1, 1, 1);        s_mode[5] = 2'd1; s_clip[5] = 9'd0;   s_exp[5] = pk(0, 0, 1, 1);
        s_in[6] = pk(511, -511, 8, -24);   s_mode[6] = 2'd2; s_clip[6] = 9'd0;   s_exp[6] = pk(511, -64, 8, -3);
        s_in[7] = pk(511, -512, 100, 101); s_mode[7] = 2'd3; s_clip[7] = 9'd100; s_exp[7] = pk(100, 0, 100, 100);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          idx, oidx;
        logic        held, blocked;
        logic [39:0] hold_d;

        rst_n = 1'b0;
        u_if.in_valid  = 0; u_if.in_data  = '0; u_if.in_mode  = 0; u_if.clip_max  = 0;
        u_if.out_ready = 1; u_if.clr_cnt  = 0;
        u_if4.in_valid = 0; u_if4.in_data = '0; u_if4.in_mode = 0; u_if4.clip_max = 0;
        u_if4.out_ready = 1; u_if4.clr_cnt = 0;
        #1;
        chk("rst_out_valid", u_if.out_valid, 0);
        chk("rst_out_data",  u_if.out_data, 0);
        chk("rst_zero_cnt",  u_if.zero_cnt, 0);
        chk("rst_in_ready",  u_if.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mode-specific single beats
        run_beat("relu", 2'd1, 9'd0, pk(-3, 0, 7, -512), pk(0, 0, 7, 0));
        chk("relu_cnt", u_if.zero_cnt, 2);
        run_beat("leaky", 2'd2, 9'd0, pk(-5, -8, -512, 100), pk(-1, -1, -64, 100));
        chk("leaky_cnt", u_if.zero_cnt, 2);
        run_beat("clip255", 2'd3, 9'd255, pk(300, 255, -1, 17), pk(255, 255, 0, 17));
        chk("clip255_cnt", u_if.zero_cnt, 3);
        run_beat("clip0", 2'd3, 9'd0, pk(300, 255, -1, 17), pk(0, 0, 0, 0));
        chk("clip0_cnt", u_if.zero_cnt, 4);
        run_beat("bypass", 2'd0, 9'd0, pk(-512, 511, -1, 0), pk(-512, 511, -1, 0));
        chk("bypass_cnt", u_if.zero_cnt, 4);

        // Back-to-back stream with out_ready low for cycles 3..5
        idx = 0; oidx = 0; held = 0; blocked = 0; hold_d = '0;
        for (int cyc = 0; cyc < 60 && oidx < 8; cyc++) begin
            @(negedge clk);
            u_if.out_ready = !(cyc >= 3 && cyc <= 5);
            if (idx < 8) begin
                u_if.in_valid = 1'b1;
                u_if.in_data  = s_in[idx];
                u_if.in_mode  = s_mode[idx];
                u_if.clip_max = s_clip[idx];
            end else begin
                u_if.in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall_valid", u_if.out_valid, 1);
                chk("stall_hold", u_if.out_data, hold_d);
            end
            if (u_if.in_valid && !u_if.in_ready) blocked = 1'b1;
            if (u_if.out_valid && u_if.out_ready) begin
                chk($sformatf("beat%0d", oidx), u_if.out_data, s_exp[oidx]);
                oidx++;
            end
            held   = u_if.out_valid && !u_if.out_ready;
            hold_d = u_if.out_data;
            if (u_if.in_valid && u_if.in_ready) idx++;
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        chk("stream_count", oidx, 8);
        chk("stream_blocked", blocked, 1);
        repeat (3) begin
            @(negedge clk);
            #1 chk("stream_no_dup", u_if.out_valid, 0);
        end
        chk("stream_cnt", u_if.zero_cnt, 10);

        // Saturation and clear-priority on the 4-bit counter instance
        repeat (3) sat_beat(1'b0);
        chk("sat_12", u_if4.zero_cnt, 12);
        sat_beat(1'b0);
        chk("sat_15a", u_if4.zero_cnt, 15);
        sat_beat(1'b0);
        chk("sat_15b", u_if4.zero_cnt, 15);
        sat_beat(1'b1);
        chk("clr_prio", u_if4.zero_cnt, 0);
        sat_beat(1'b0);
        chk("after_clr", u_if4.zero_cnt, 4);

        // Fill both stages while stalled, then reset asynchronously mid-cycle
        u_if.out_ready = 1'b0;
        @(negedge clk);
        u_if.in_valid = 1'b1; u_if.in_mode = 2'd0; u_if.in_data = pk(1, 2, 3, 4);
        @(posedge clk);
        @(negedge clk);
        u_if.in_data = pk(5, 6, 7, 8);
        @(posedge clk);
        #1 u_if.in_valid = 1'b0;
        chk("full_in_ready", u_if.in_ready, 0);
        chk("full_out_valid", u_if.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", u_if.out_valid, 0);
        chk("arst_in_ready", u_if.in_ready, 1);
        chk("arst_out_data", u_if.out_data, 0);
        chk("arst_zero_cnt", u_if.zero_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1 chk("post_rst_stale", u_if.out_valid, 0);
        end
        chk("post_rst_cnt", u_if.zero_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/act_unit_pipe.md
Name: act_unit_pipe

Overview:
- Parametrised, pipelined activation stage for the CNN datapath.
- Processes LANES signed DATA_W-bit elements per beat.
- Supports four activation modes selected per beat: bypass, ReLU, leaky ReLU and clipped ReLU.
- Sits between the accumulator/requantiser output and the next layer's input buffer, with valid/ready on both sides.
- Keeps a saturating counter of elements zeroed by negative inputs, for sparsity statistics.

Parameters:
- DATA_W, 10, width of one signed element
- LANES, 4, elements per beat
- LEAK_SHIFT, 3, leaky slope is 2^-LEAK_SHIFT (arithmetic right shift); legal range 1..DATA_W-1
- CNT_W, 16, width of the zero-count statistic

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat
- in_data  input  LANES*DATA_W  packed signed elements, lane i at [i*DATA_W +: DATA_W]
- in_mode  input  2  activation mode for this beat: 0 bypass, 1 ReLU, 2 leaky, 3 clip
- clip_max  input  DATA_W-1  unsigned clip ceiling for mode 3, sampled with the beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the output beat
- out_data  output  LANES*DATA_W  packed signed results, same lane layout as in_data
- clr_cnt  input  1  synchronous clear of zero_cnt
- zero_cnt  output  CNT_W  saturating count of elements forced to zero

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- On reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, zero_cnt=0.
- Reset mid-stream discards all in-flight beats; no partial beat is emitted afterwards.

Pipeline:
- Two register stages.
- S1 captures in_data, in_mode and clip_max.
- S2 holds the computed result and drives out_data.
- out_valid = s2_valid.
- adv2 = ~s2_valid | out_ready.
- adv1 = ~s1_valid | adv2.
- in_ready = adv1. This is a combinational ready chain; there are no combinational paths from in_* to out_*.
- Input handshake: in_valid & in_ready. S1 loads and s1_valid := 1. Otherwise, if adv1, s1_valid := 0.
- When adv2: S2 loads the S1 result and s2_valid := s1_valid.
- Latency is exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- While out_valid=1 and out_ready=0, out_data and out_valid hold stable. No beat is dropped or duplicated.
- Mode and clip_max travel with their beat. Changing them between beats affects only later beats.

Per-lane function (x signed DATA_W):
- mode 0: y = x.
- mode 1: y = (x<0) ? 0 : x.
- mode 2: y = (x<0) ? (x >>> LEAK_SHIFT) : x. The shift is arithmetic and rounds toward -inf, e.g. -5>>>3 = -1 and -8>>>3 = -1.
- mode 3: y = (x<0) ? 0 : min(x, clip_max). clip_max is zero-extended; clip_max=0 forces all outputs to 0.
- Most negative input (-2^(DATA_W-1)): mode 2 gives -2^(DATA_W-1-LEAK_SHIFT). There is no overflow in any mode.

Zero counter:
- On each output handshake (out_valid & out_ready), zero_cnt increases by the number of lanes in that beat with x<0 in mode 1 or 3.
- Mode 3 outputs that are 0 only because clip_max=0 with x>=0 are not counted.
- zero_cnt saturates at 2^CNT_W-1.
- clr_cnt=1 sets zero_cnt=0 and takes priority over a same-cycle increment; that cycle's increment is lost.

Test Plan:
- Reset then single beat, mode 1, lanes {-3, 0, 7, -512}, out_ready=1 -> out_valid exactly 2 cycles later with {0, 0, 7, 0}; zero_cnt=2.
- Mode 2, lanes {-5, -8, -512, 100} (LEAK_SHIFT=3) -> {-1, -1, -64, 100}; zero_cnt unchanged.
- Mode 3, clip_max=255, lanes {300, 255, -1, 17} -> {255, 255, 0, 17}; zero_cnt+1. Same beat with clip_max=0 -> {0, 0, 0, 0}, zero_cnt+1 only.
- 8 back-to-back beats with alternating modes; hold out_ready=0 for 3 cycles mid-stream -> in_ready drops once both stages are full, out_data is stable while stalled, all 8 results arrive in order with correct per-beat modes, no loss or duplication.
- CNT_W=4, stream mode-1 beats of all-negative lanes -> zero_cnt saturates at 15. Assert clr_cnt in the same cycle as a counting handshake -> zero_cnt=0.
- Assert rst_n=0 asynchronously with both stages full -> out_valid and in_ready-blocking state clear immediately. After release, no stale beat appears and zero_cnt=0.
